// File: rtl/mest_pro_mm_responder_if.sv
// Main-memory request/response bundle between the execute unit (master) and the responder (slave).
// Signal prefixes are from the responder's point of view: i_* driven by the initiator, o_* by the responder.
interface mest_pro_mm_responder_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 8
);
    logic                 i_mm_select;
    logic                 i_cs;
    logic                 i_we;
    logic [ADDR_BITS-1:0] i_mm_addr;
    logic [DATA_BITS-1:0] i_mm_dat;
    logic [DATA_BITS-1:0] o_mm_rdata;
    logic                 o_mm_ack;
    logic                 o_mm_busy;
    logic                 o_mm_err;

    modport master (
        output i_mm_select, i_cs, i_we, i_mm_addr, i_mm_dat,
        input  o_mm_rdata, o_mm_ack, o_mm_busy, o_mm_err
    );

    modport slave (
        input  i_mm_select, i_cs, i_we, i_mm_addr, i_mm_dat,
        output o_mm_rdata, o_mm_ack, o_mm_busy, o_mm_err
    );
endinterface

// File: rtl/mest_pro_mm_responder.sv
// Main-memory responder: one load/store at a time, ack WAIT_CYCLES edges after the request is sampled.
// Four-phase handshake: ack held until select drops; select dropping during the wait aborts the access.
module mest_pro_mm_responder #(
    parameter int ADDR_BITS   = 16,
    parameter int DATA_BITS   = 8,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    i_reset_n,
    mest_pro_mm_responder_if.slave  mm
);

    localparam int                 IDX_BITS  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_BITS:0] DEPTH_CMP = (ADDR_BITS + 1)'(MEM_DEPTH);
    localparam logic [3:0]         CNT_LOAD  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_dat;
    logic                 r_we;
    logic [DATA_BITS-1:0] r_rdata;
    logic                 r_ack;
    logic                 r_busy;
    logic                 r_err;

    logic [DATA_BITS-1:0] r_mem [MEM_DEPTH];

    logic                 w_oor;
    logic [IDX_BITS-1:0]  w_idx;
    logic                 w_access;
    logic                 w_commit;

    // Range check on the full latched address so high-address aliases never reach the array.
    assign w_oor    = ({1'b0, r_addr} >= DEPTH_CMP);
    assign w_idx    = r_addr[IDX_BITS-1:0];
    assign w_access = (r_state == ST_WAIT) && mm.i_mm_select && (r_cnt == 4'd1);
    assign w_commit = w_access && r_we && !w_oor;

    // Storage is deliberately not reset; reset forces IDLE so no commit can happen while it is held.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= r_dat;
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_dat   <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mm.i_mm_select && mm.i_cs) begin
                        r_addr  <= mm.i_mm_addr;
                        r_dat   <= mm.i_mm_dat;
                        r_we    <= mm.i_we;
                        r_cnt   <= CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (!mm.i_mm_select) begin
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_ack   <= 1'b1;
                        r_err   <= w_oor;
                        r_state <= ST_ACK;
                        if (!r_we) begin
                            r_rdata <= w_oor ? '0 : r_mem[w_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                ST_ACK: begin
                    if (!mm.i_mm_select) begin
                        r_ack   <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= 4'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mm.o_mm_rdata = r_rdata;
    assign mm.o_mm_ack   = r_ack;
    assign mm.o_mm_busy  = r_busy;
    assign mm.o_mm_err   = r_err;

endmodule

// File: tb/tb_mest_pro_mm_responder.sv
// Directed bench for the main-memory responder; expected responses are queued at request time and popped on ack.
module tb_mest_pro_mm_responder;

    localparam int WAIT_CYCLES = 3;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t       sb [$];
    logic [7:0] model_mem [256];
    logic [7:0] model_rdata = 8'h00;

    always #5 clk = ~clk;

    mest_pro_mm_responder_if #(.ADDR_BITS(16), .DATA_BITS(8)) mm ();

    mest_pro_mm_responder #(
        .ADDR_BITS  (16),
        .DATA_BITS  (8),
        .MEM_DEPTH  (256),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk      (clk),
        .i_reset_n(rst_n),
        .mm       (mm)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [7:0] exp_rdata);
        check({tag, " ack"},   32'(mm.o_mm_ack),   32'd0);
        check({tag, " busy"},  32'(mm.o_mm_busy),  32'd0);
        check({tag, " err"},   32'(mm.o_mm_err),   32'd0);
        check({tag, " rdata"}, 32'(mm.o_mm_rdata), 32'(exp_rdata));
    endtask

    // Called just after a falling edge; returns just after the falling edge that follows ack clearing.
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [7:0] dat, input string tag);
        exp_t e;
        exp_t got;
        int   lat;
        logic oor;
        oor   = (addr >= 16'd256);
        e.err = oor;
        if (we) begin
            e.rdata = model_rdata;
            if (!oor) model_mem[addr[7:0]] = dat;
        end else begin
            e.rdata     = oor ? 8'h00 : model_mem[addr[7:0]];
            model_rdata = e.rdata;
        end
        sb.push_back(e);

        mm.i_mm_select = 1'b1;
        mm.i_cs        = 1'b1;
        mm.i_we        = we;
        mm.i_mm_addr   = addr;
        mm.i_mm_dat    = dat;
        @(negedge clk);
        check({tag, " busy_rise"}, 32'(mm.o_mm_busy), 32'd1);
        // Scramble the request fields: the responder must use its latched copies.
        mm.i_mm_addr = ~addr;
        mm.i_mm_dat  = ~dat;
        mm.i_we      = ~we;
        lat = 1;
        while (!mm.o_mm_ack && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " ack_latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
        if (mm.o_mm_ack) begin
            got = sb.pop_front();
            check({tag, " rdata"}, 32'(mm.o_mm_rdata), 32'(got.rdata));
            check({tag, " err"},   32'(mm.o_mm_err),   32'(got.err));
        end
        mm.i_mm_select = 1'b0;
        @(negedge clk);
        check_idle_outputs({tag, " release"}, model_rdata);
    endtask

    initial begin
        mm.i_mm_select = 1'b0;
        mm.i_cs        = 1'b0;
        mm.i_we        = 1'b0;
        mm.i_mm_addr   = '0;
        mm.i_mm_dat    = '0;

        // Reset values, both while held and after release
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_held", 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_released", 8'h00);

        // Known contents for the locations probed later
        do_req(1'b1, 16'h0000, 8'h11, "pre0");
        do_req(1'b1, 16'h0001, 8'h22, "pre1");
        do_req(1'b1, 16'h0002, 8'h33, "pre2");
        do_req(1'b1, 16'h0003, 8'h44, "pre3");
        do_req(1'b1, 16'h0005, 8'h55, "pre5");

        // Store/load round trip
        do_req(1'b1, 16'h0012, 8'hA5, "rt_store");
        do_req(1'b0, 16'h0012, 8'h00, "rt_load");

        // Out of range: 0x0100 aliases index 0 in the low bits but must not touch it
        do_req(1'b1, 16'h0100, 8'h3C, "oor_store");
        do_req(1'b0, 16'h0100, 8'h00, "oor_load");
        do_req(1'b0, 16'h0000, 8'h00, "oor_alias_load");

        // Abort: select dropped after one cycle in WAIT
        mm.i_mm_select = 1'b1;
        mm.i_cs        = 1'b1;
        mm.i_we        = 1'b1;
        mm.i_mm_addr   = 16'h0005;
        mm.i_mm_dat    = 8'h77;
        @(negedge clk);
        check("abort busy_rise", 32'(mm.o_mm_busy), 32'd1);
        @(negedge clk);
        check("abort no_ack_wait", 32'(mm.o_mm_ack), 32'd0);
        mm.i_mm_select = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort idle", 32'({mm.o_mm_ack, mm.o_mm_busy, mm.o_mm_err}), 32'd0);
        end
        check("abort rdata_kept", 32'(mm.o_mm_rdata), 32'(model_rdata));
        do_req(1'b0, 16'h0005, 8'h00, "abort_load");

        // cs gating: a store request with chip select low for 10 cycles
        mm.i_mm_select = 1'b1;
        mm.i_cs        = 1'b0;
        mm.i_we        = 1'b1;
        mm.i_mm_addr   = 16'h0000;
        mm.i_mm_dat    = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("cs_gate busy", 32'(mm.o_mm_busy), 32'd0);
            check("cs_gate ack",  32'(mm.o_mm_ack),  32'd0);
        end
        mm.i_mm_select = 1'b0;
        @(negedge clk);
        do_req(1'b0, 16'h0000, 8'h00, "cs_gate_load");

        // Back-to-back loads, select low for exactly one edge between them
        for (int a = 0; a < 4; a++) begin
            do_req(1'b0, 16'(a), 8'h00, "b2b_load");
        end

        // Reset during the WAIT phase of a store
        mm.i_mm_select = 1'b1;
        mm.i_cs        = 1'b1;
        mm.i_we        = 1'b1;
        mm.i_mm_addr   = 16'h0001;
        mm.i_mm_dat    = 8'h99;
        @(negedge clk);
        check("rst_mid busy_rise", 32'(mm.o_mm_busy), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_rdata = 8'h00;
        check_idle_outputs("rst_mid async", 8'h00);
        mm.i_mm_select = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_mid released", 8'h00);
        do_req(1'b0, 16'h0001, 8'h00, "rst_mid_load");

        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
